// File: rtl/stdp_train_sequencer.sv
// Stimulus sequencer for the two-neuron HH/STDP core: runs pre->post pairing
// trials, then a pre-only test window in which neuron spike edges are counted.
module stdp_train_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TRIAL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         cfg_amp_pre,
  input  logic [7:0]         cfg_amp_post,
  input  logic [CNT_W-1:0]   cfg_t_pulse,
  input  logic [CNT_W-1:0]   cfg_t_gap,
  input  logic [CNT_W-1:0]   cfg_t_rest,
  input  logic [CNT_W-1:0]   cfg_t_test,
  input  logic [TRIAL_W-1:0] cfg_n_trials,
  input  logic               spike_pre,
  input  logic               spike_post,
  output logic [7:0]         i_pre,
  output logic [7:0]         i_post,
  output logic               busy,
  output logic               done,
  output logic [2:0]         phase,
  output logic [TRIAL_W-1:0] trial_idx,
  output logic [7:0]         pre_spike_cnt,
  output logic [7:0]         post_spike_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_PRE = 3'd1, S_GAP1 = 3'd2, S_POST = 3'd3,
    S_GAP2 = 3'd4, S_REST = 3'd5, S_TEST = 3'd6, S_DONE = 3'd7
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [TRIAL_W-1:0] trial_nxt;
  logic               accept;
  logic               last_trial;
  logic               spike_pre_p1, spike_post_p1;

  logic [7:0]         amp_pre_r, amp_post_r, amp_pre_v, amp_post_v;
  logic [CNT_W-1:0]   t_pulse_r, t_gap_r, t_rest_r, t_test_r;
  logic [CNT_W-1:0]   t_pulse_v, t_gap_v, t_rest_v, t_test_v;
  logic [TRIAL_W-1:0] n_trials_r, n_trials_v;

  // A zero duration still occupies one cycle; the counter holds cycles left minus one.
  function automatic logic [CNT_W-1:0] load_of(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign accept = (state == S_IDLE) && start && !abort;

  // On the accepting edge the live config is used, otherwise the latched copy.
  assign amp_pre_v  = accept ? cfg_amp_pre  : amp_pre_r;
  assign amp_post_v = accept ? cfg_amp_post : amp_post_r;
  assign t_pulse_v  = accept ? cfg_t_pulse  : t_pulse_r;
  assign t_gap_v    = accept ? cfg_t_gap    : t_gap_r;
  assign t_rest_v   = accept ? cfg_t_rest   : t_rest_r;
  assign t_test_v   = accept ? cfg_t_test   : t_test_r;
  assign n_trials_v = accept ? cfg_n_trials : n_trials_r;

  assign last_trial = ({1'b0, trial_idx} + (TRIAL_W+1)'(1)) >= {1'b0, n_trials_v};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    trial_nxt = trial_idx;
    if (state == S_IDLE) begin
      if (accept) begin
        trial_nxt = '0;
        if (n_trials_v == '0) begin
          state_nxt = S_TEST;
          cnt_nxt   = load_of(t_test_v);
        end else begin
          state_nxt = S_PRE;
          cnt_nxt   = load_of(t_pulse_v);
        end
      end
    end else if (abort) begin
      state_nxt = S_IDLE;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_W'(1);
    end else begin
      case (state)
        S_PRE:  begin state_nxt = S_GAP1; cnt_nxt = load_of(t_gap_v);   end
        S_GAP1: begin state_nxt = S_POST; cnt_nxt = load_of(t_pulse_v); end
        S_POST: begin state_nxt = S_GAP2; cnt_nxt = load_of(t_gap_v);   end
        S_GAP2: begin state_nxt = S_REST; cnt_nxt = load_of(t_rest_v);  end
        S_REST: begin
          if (last_trial) begin
            state_nxt = S_TEST;
            cnt_nxt   = load_of(t_test_v);
          end else begin
            state_nxt = S_PRE;
            cnt_nxt   = load_of(t_pulse_v);
            trial_nxt = trial_idx + TRIAL_W'(1);
          end
        end
        S_TEST:  state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Stage p1: registered state, outputs decoded from the next state, spike edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      trial_idx      <= '0;
      phase          <= 3'd0;
      i_pre          <= 8'd0;
      i_post         <= 8'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pre_spike_cnt  <= 8'd0;
      post_spike_cnt <= 8'd0;
      spike_pre_p1   <= 1'b0;
      spike_post_p1  <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      trial_idx     <= trial_nxt;
      phase         <= state_nxt;
      i_pre         <= (state_nxt == S_PRE || state_nxt == S_TEST) ? amp_pre_v : 8'd0;
      i_post        <= (state_nxt == S_POST) ? amp_post_v : 8'd0;
      busy          <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done          <= (state_nxt == S_DONE);
      spike_pre_p1  <= spike_pre;
      spike_post_p1 <= spike_post;
      if (accept) begin
        pre_spike_cnt  <= 8'd0;
        post_spike_cnt <= 8'd0;
      end else if (state == S_TEST && !abort) begin
        if (spike_pre && !spike_pre_p1)   pre_spike_cnt  <= sat_inc(pre_spike_cnt);
        if (spike_post && !spike_post_p1) post_spike_cnt <= sat_inc(post_spike_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      amp_pre_r  <= cfg_amp_pre;
      amp_post_r <= cfg_amp_post;
      t_pulse_r  <= cfg_t_pulse;
      t_gap_r    <= cfg_t_gap;
      t_rest_r   <= cfg_t_rest;
      t_test_r   <= cfg_t_test;
      n_trials_r <= cfg_n_trials;
    end
  end

endmodule

// File: tb/tb_stdp_train_sequencer.sv
// Directed bench for stdp_train_sequencer: table of run configurations with
// hand-computed completion cycles and spike counts, plus abort/reset sequences.
module tb_stdp_train_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  cfg_amp_pre, cfg_amp_post;
  logic [15:0] cfg_t_pulse, cfg_t_gap, cfg_t_rest, cfg_t_test;
  logic [7:0]  cfg_n_trials;
  logic        spike_pre, spike_post;
  logic [7:0]  i_pre, i_post;
  logic        busy, done;
  logic [2:0]  phase;
  logic [7:0]  trial_idx, pre_spike_cnt, post_spike_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  stdp_train_sequencer #(.CNT_W(16), .TRIAL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_amp_pre(cfg_amp_pre), .cfg_amp_post(cfg_amp_post),
    .cfg_t_pulse(cfg_t_pulse), .cfg_t_gap(cfg_t_gap), .cfg_t_rest(cfg_t_rest),
    .cfg_t_test(cfg_t_test), .cfg_n_trials(cfg_n_trials),
    .spike_pre(spike_pre), .spike_post(spike_post),
    .i_pre(i_pre), .i_post(i_post), .busy(busy), .done(done), .phase(phase),
    .trial_idx(trial_idx), .pre_spike_cnt(pre_spike_cnt), .post_spike_cnt(post_spike_cnt)
  );

  typedef struct {
    logic [15:0] p, g, r, t;
    logic [7:0]  n, amp_pre, amp_post;
    int          mode;
    bit          restart;
    int          exp_done, exp_pre, exp_post;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spike stimulus per pattern and cycle, returned as {pre, post}
  function automatic logic [1:0] spk(input int mode, input int c);
    logic a, b;
    a = 1'b0;
    b = 1'b0;
    case (mode)
      1: begin
        a = (c >= 70 && c <= 100);
        b = (c >= 10 && c <= 12) || (c >= 75 && c <= 77) ||
            (c >= 80 && c <= 82) || (c >= 92 && c <= 94);
      end
      2: begin
        a = (c % 3 == 0);
        b = (c % 2 == 1);
      end
      3: begin
        a = (c == 23);
        b = (c == 21 || c == 24);
      end
      default: ;
    endcase
    return {a, b};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int pe, ge, re, len, nl, o, ph, ti, ep, eq;
    pe  = (v.p == 0) ? 1 : int'(v.p);
    ge  = (v.g == 0) ? 1 : int'(v.g);
    re  = (v.r == 0) ? 1 : int'(v.r);
    len = 2*pe + 2*ge + re;
    nl  = int'(v.n) * len;
    cfg_t_pulse = v.p;  cfg_t_gap = v.g;  cfg_t_rest = v.r;  cfg_t_test = v.t;
    cfg_n_trials = v.n; cfg_amp_pre = v.amp_pre; cfg_amp_post = v.amp_post;
    start = 1'b1;
    {spike_pre, spike_post} = spk(v.mode, 0);
    for (int c = 1; c <= v.exp_done + 1; c++) begin
      tick();
      if (c == 1) begin
        cfg_t_pulse = 16'd9; cfg_t_gap = 16'd9; cfg_t_rest = 16'd9; cfg_t_test = 16'd9;
        cfg_n_trials = 8'd7; cfg_amp_pre = 8'hFF; cfg_amp_post = 8'hFF;
      end
      start = v.restart && c >= 10 && c <= 40;
      ti = (v.n == 0) ? 0 : int'(v.n) - 1;
      if (c <= nl) begin
        o  = (c - 1) % len;
        ti = (c - 1) / len;
        if (o < pe) ph = 1;
        else if (o < pe + ge) ph = 2;
        else if (o < 2*pe + ge) ph = 3;
        else if (o < 2*pe + 2*ge) ph = 4;
        else ph = 5;
      end else if (c < v.exp_done) ph = 6;
      else if (c == v.exp_done) ph = 7;
      else ph = 0;
      ep = (ph == 1 || ph == 6) ? int'(v.amp_pre) : 0;
      eq = (ph == 3) ? int'(v.amp_post) : 0;
      chk($sformatf("v%0d.phase@%0d", idx, c), phase, ph);
      chk($sformatf("v%0d.i_pre@%0d", idx, c), i_pre, ep);
      chk($sformatf("v%0d.i_post@%0d", idx, c), i_post, eq);
      chk($sformatf("v%0d.busy@%0d", idx, c), busy, (ph >= 1 && ph <= 6) ? 1 : 0);
      chk($sformatf("v%0d.done@%0d", idx, c), done, (ph == 7) ? 1 : 0);
      chk($sformatf("v%0d.trial_idx@%0d", idx, c), trial_idx, ti);
      if (c == 1) begin
        chk($sformatf("v%0d.pre_cnt_clr", idx), pre_spike_cnt, 0);
        chk($sformatf("v%0d.post_cnt_clr", idx), post_spike_cnt, 0);
      end
      if (c >= v.exp_done) begin
        chk($sformatf("v%0d.pre_cnt@%0d", idx, c), pre_spike_cnt, v.exp_pre);
        chk($sformatf("v%0d.post_cnt@%0d", idx, c), post_spike_cnt, v.exp_post);
      end
      {spike_pre, spike_post} = spk(v.mode, c);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".phase"}, phase, 0);
    chk({tag, ".i_pre"}, i_pre, 0);
    chk({tag, ".i_post"}, i_post, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".trial_idx"}, trial_idx, 0);
    chk({tag, ".pre_cnt"}, pre_spike_cnt, 0);
    chk({tag, ".post_cnt"}, post_spike_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    spike_pre = 1'b0; spike_post = 1'b0;
    cfg_amp_pre = 8'd0; cfg_amp_post = 8'd0;
    cfg_t_pulse = 16'd0; cfg_t_gap = 16'd0; cfg_t_rest = 16'd0; cfg_t_test = 16'd0;
    cfg_n_trials = 8'd0;

    //          p      g      r      t        n     amp_pre amp_post mode rs done pre post
    vecs[0] = '{16'd5, 16'd2, 16'd10, 16'd20,   8'd3, 8'h80, 8'h80, 1, 1'b0,   93,   0,   3};
    vecs[1] = '{16'd5, 16'd2, 16'd10, 16'd4,    8'd0, 8'h11, 8'h22, 0, 1'b0,    5,   0,   0};
    vecs[2] = '{16'd0, 16'd0, 16'd0,  16'd0,    8'd1, 8'h5A, 8'hA5, 0, 1'b0,    7,   0,   0};
    vecs[3] = '{16'd1, 16'd1, 16'd1,  16'd1000, 8'd1, 8'h33, 8'h44, 2, 1'b0, 1006, 255, 255};
    vecs[4] = '{16'd3, 16'd0, 16'd2,  16'd3,    8'd2, 8'h21, 8'h42, 3, 1'b0,   24,   1,   1};
    vecs[5] = '{16'd5, 16'd2, 16'd10, 16'd20,   8'd3, 8'h80, 8'h80, 0, 1'b1,   93,   0,   0};

    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort during the test window; counts must survive, no done pulse
    cfg_t_pulse = 16'd5; cfg_t_gap = 16'd2; cfg_t_rest = 16'd10; cfg_t_test = 16'd50;
    cfg_n_trials = 8'd0; cfg_amp_pre = 8'h80; cfg_amp_post = 8'h80;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 30) begin
        chk("abort.phase_before", phase, 6);
        chk("abort.post_cnt_before", post_spike_cnt, 2);
      end
      if (c == 31) begin
        chk("abort.phase", phase, 0);
        chk("abort.i_pre", i_pre, 0);
        chk("abort.i_post", i_post, 0);
        chk("abort.busy", busy, 0);
        chk("abort.post_cnt_held", post_spike_cnt, 2);
        chk("abort.pre_cnt_held", pre_spike_cnt, 0);
      end
      if (c >= 31) begin
        chk($sformatf("abort.no_done@%0d", c), done, 0);
        chk($sformatf("abort.idle@%0d", c), phase, 0);
      end
      spike_post = (c == 5 || c == 20);
      abort      = (c == 30);
    end

    // start together with abort in IDLE must not launch a run
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort.phase", phase, 0);
    chk("start_abort.busy", busy, 0);
    tick();
    chk("start_abort.phase2", phase, 0);

    // Reset mid-run overrides simultaneous start and abort
    cfg_t_pulse = 16'd5; cfg_t_gap = 16'd2; cfg_t_rest = 16'd10; cfg_t_test = 16'd20;
    cfg_n_trials = 8'd3; cfg_amp_pre = 8'h80; cfg_amp_post = 8'h80;
    start = 1'b1;
    for (int c = 1; c <= 52; c++) begin
      tick();
      if (c == 1) start = 1'b0;
      if (c == 50) begin
        chk("rst.trial_before", trial_idx, 2);
        chk("rst.busy_before", busy, 1);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
      end else if (c == 51) begin
        chk_all_zero("rst_mid");
        rst = 1'b0; start = 1'b0; abort = 1'b0;
      end else if (c == 52) begin
        chk("rst.idle_after", phase, 0);
        chk("rst.busy_after", busy, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
